// File: rtl/kick_pkg.sv
// Shared definitions for the kick impulse controller: FSM states, kicker
// encoding, fixed-point scale and datapath widths.
package kick_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        HOLD     = 2'd2,
        COOLDOWN = 2'd3
    } kick_state_e;

    // Speeds are expressed in 1/64 pixel per frame.
    localparam int FIXED_POINT_MULTIPLIER = 64;

    localparam logic KICKER_PLAYER = 1'b0;
    localparam logic KICKER_BOT    = 1'b1;

    localparam int POS_W    = 11;
    localparam int SPEED_W  = 12;
    localparam int OFFSET_W = 12;
    localparam int YCALC_W  = 16;
    localparam int STAT_W   = 8;

endpackage

// File: rtl/kick_y_shaper.sv
// Combinational Y impulse shaper: ball-to-rod-centre offset, gain and
// symmetric saturation. One copy per rod; the top muxes by kick winner.
module kick_y_shaper
    import kick_pkg::*;
#(
    parameter int ROD_HALF_H       = 16,
    parameter int Y_GAIN           = 4,
    parameter int KICK_SPEED_Y_MAX = 150
)
(
    input  logic        [POS_W-1:0]   rodTLY_i,
    input  logic        [POS_W-1:0]   ballTLY_i,
    output logic signed [SPEED_W-1:0] ySpeed_o
);

    localparam logic signed [OFFSET_W-1:0] HALF_H = OFFSET_W'(ROD_HALF_H);
    localparam logic signed [YCALC_W-1:0]  GAIN   = YCALC_W'(Y_GAIN);
    localparam logic signed [YCALC_W-1:0]  Y_MAX  = YCALC_W'(KICK_SPEED_Y_MAX);
    localparam logic signed [YCALC_W-1:0]  Y_MIN  = -Y_MAX;

    logic signed [OFFSET_W-1:0] ballExt;
    logic signed [OFFSET_W-1:0] rodExt;
    logic signed [OFFSET_W-1:0] offset;
    logic signed [YCALC_W-1:0]  offsetWide;
    logic signed [YCALC_W-1:0]  yCalc;

    // Ball Y is an unsigned screen coordinate, rod Y is signed; widen both
    // to the signed offset width before subtracting the rod centre.
    assign ballExt    = {1'b0, ballTLY_i};
    assign rodExt     = {rodTLY_i[POS_W-1], rodTLY_i};
    assign offset     = ballExt - rodExt - HALF_H;
    assign offsetWide = {{(YCALC_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    assign yCalc      = offsetWide * GAIN;

    // Saturate the scaled offset so a glancing hit never exceeds the
    // maximum vertical impulse in either direction.
    always_comb begin
        ySpeed_o = yCalc[SPEED_W-1:0];
        if (yCalc > Y_MAX) begin
            ySpeed_o = Y_MAX[SPEED_W-1:0];
        end else if (yCalc < Y_MIN) begin
            ySpeed_o = Y_MIN[SPEED_W-1:0];
        end
    end

endmodule

// File: rtl/kick_impulse_ctrl.sv
// Kick impulse controller: edge-detects the bot and player kick levels,
// arbitrates one kick (player wins ties), latches an X/Y speed impulse and
// strobes it into the ball mover on HOLD_FRAMES consecutive frames, then
// blocks further kicks for COOLDOWN_FRAMES frames.
// Optional build macro KICK_STATS_EN adds saturating per-side kick counters
// on ports bot_kicks / player_kicks.
module kick_impulse_ctrl
    import kick_pkg::*;
#(
    parameter int KICK_SPEED_X     = 300,
    parameter int KICK_SPEED_Y_MAX = 150,
    parameter int Y_GAIN           = 4,
    parameter int ROD_HALF_H       = 16,
    parameter int HOLD_FRAMES      = 4,
    parameter int COOLDOWN_FRAMES  = 15
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      bot_kick,
    input  logic                      player_kick,
    input  logic        [POS_W-1:0]   botTLY,
    input  logic        [POS_W-1:0]   playerTLY,
    input  logic        [POS_W-1:0]   ballTLY,
    output logic                      load_speed,
    output logic signed [SPEED_W-1:0] Xspeed_out,
    output logic signed [SPEED_W-1:0] Yspeed_out,
    output logic                      kicker,
    output logic                      busy
`ifdef KICK_STATS_EN
    ,
    output logic        [STAT_W-1:0]  bot_kicks,
    output logic        [STAT_W-1:0]  player_kicks
`endif
);

    // One frame counter serves both HOLD and COOLDOWN, so size it for the
    // longer of the two phases (both must be at least one frame).
    localparam int CNT_MAX = (HOLD_FRAMES > COOLDOWN_FRAMES) ? HOLD_FRAMES : COOLDOWN_FRAMES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic signed [SPEED_W-1:0] X_POS = SPEED_W'(KICK_SPEED_X);
    localparam logic signed [SPEED_W-1:0] X_NEG = -X_POS;

    kick_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      botKick_q, playerKick_q;
    logic                      loadSpeed_q, loadSpeed_d;
    logic signed [SPEED_W-1:0] xSpeed_q, xSpeed_d;
    logic signed [SPEED_W-1:0] ySpeed_q, ySpeed_d;
    logic                      kicker_q, kicker_d;

    logic                      botEdge, playerEdge;
    logic                      acceptPlayer, acceptBot;
    logic signed [SPEED_W-1:0] botY, playerY;

    kick_y_shaper #(
        .ROD_HALF_H       (ROD_HALF_H),
        .Y_GAIN           (Y_GAIN),
        .KICK_SPEED_Y_MAX (KICK_SPEED_Y_MAX)
    ) u_botShaper (
        .rodTLY_i  (botTLY),
        .ballTLY_i (ballTLY),
        .ySpeed_o  (botY)
    );

    kick_y_shaper #(
        .ROD_HALF_H       (ROD_HALF_H),
        .Y_GAIN           (Y_GAIN),
        .KICK_SPEED_Y_MAX (KICK_SPEED_Y_MAX)
    ) u_playerShaper (
        .rodTLY_i  (playerTLY),
        .ballTLY_i (ballTLY),
        .ySpeed_o  (playerY)
    );

    // Rising edges only; kicks are only accepted while IDLE and the player
    // wins when both rods fire in the same cycle.
    assign botEdge      = bot_kick & ~botKick_q;
    assign playerEdge   = player_kick & ~playerKick_q;
    assign acceptPlayer = (state_q == IDLE) & playerEdge;
    assign acceptBot    = (state_q == IDLE) & botEdge & ~playerEdge;

    // State, counter and output registers. Edge-detect history resets to 1
    // so a kick level already high when reset releases is not seen as a kick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            botKick_q    <= 1'b1;
            playerKick_q <= 1'b1;
            loadSpeed_q  <= 1'b0;
            xSpeed_q     <= '0;
            ySpeed_q     <= '0;
            kicker_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            botKick_q    <= bot_kick;
            playerKick_q <= player_kick;
            loadSpeed_q  <= loadSpeed_d;
            xSpeed_q     <= xSpeed_d;
            ySpeed_q     <= ySpeed_d;
            kicker_q     <= kicker_d;
        end
    end

    // Next-state logic: latch the impulse on an accepted kick, strobe it on
    // each frame of the hold phase, then count down the cooldown frames.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loadSpeed_d = 1'b0;
        xSpeed_d    = xSpeed_q;
        ySpeed_d    = ySpeed_q;
        kicker_d    = kicker_q;

        case (state_q)
            IDLE: begin
                if (acceptPlayer || acceptBot) begin
                    kicker_d = acceptPlayer ? KICKER_PLAYER : KICKER_BOT;
                    xSpeed_d = acceptPlayer ? X_NEG : X_POS;
                    ySpeed_d = acceptPlayer ? playerY : botY;
                    cnt_d    = '0;
                    state_d  = ARM;
                end
            end
            ARM: begin
                if (startOfFrame) begin
                    loadSpeed_d = 1'b1;
                    cnt_d       = HOLD_LOAD;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (startOfFrame) begin
                    if (cnt_q == '0) begin
                        cnt_d   = COOL_LOAD;
                        state_d = COOLDOWN;
                    end else begin
                        loadSpeed_d = 1'b1;
                        cnt_d       = cnt_q - CNT_ONE;
                    end
                end
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign load_speed = loadSpeed_q;
    assign Xspeed_out = xSpeed_q;
    assign Yspeed_out = ySpeed_q;
    assign kicker     = kicker_q;
    assign busy       = (state_q != IDLE);

`ifdef KICK_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] botKicks_q, botKicks_d;
    logic [STAT_W-1:0] playerKicks_q, playerKicks_d;

    // Count accepted kicks per side, saturating instead of wrapping.
    always_comb begin
        botKicks_d    = botKicks_q;
        playerKicks_d = playerKicks_q;
        if (acceptBot && (botKicks_q != STAT_MAX)) begin
            botKicks_d = botKicks_q + STAT_W'(1);
        end
        if (acceptPlayer && (playerKicks_q != STAT_MAX)) begin
            playerKicks_d = playerKicks_q + STAT_W'(1);
        end
    end

    // Kick statistic registers, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            botKicks_q    <= '0;
            playerKicks_q <= '0;
        end else begin
            botKicks_q    <= botKicks_d;
            playerKicks_q <= playerKicks_d;
        end
    end

    assign bot_kicks    = botKicks_q;
    assign player_kicks = playerKicks_q;
`endif

endmodule

// File: tb/tb_kick_impulse_ctrl.sv
// Self-checking bench for kick_impulse_ctrl: directed scenarios followed by
// randomized kicks, positions and frame spacing, all compared each cycle
// against a frame-counting reference model of a kick's lifetime.
module tb_kick_impulse_ctrl;

    localparam int SPEED_X   = 300;
    localparam int SPEED_YMX = 150;
    localparam int GAIN      = 4;
    localparam int HALF_H    = 16;
    localparam int HOLD      = 4;
    localparam int COOL      = 15;

    logic               clk;
    logic               reset;
    logic               startOfFrame;
    logic               bot_kick;
    logic               player_kick;
    logic        [10:0] botTLY;
    logic        [10:0] playerTLY;
    logic        [10:0] ballTLY;
    logic               load_speed;
    logic signed [11:0] Xspeed_out;
    logic signed [11:0] Yspeed_out;
    logic               kicker;
    logic               busy;
`ifdef KICK_STATS_EN
    logic        [7:0]  bot_kicks;
    logic        [7:0]  player_kicks;
`endif

    kick_impulse_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .bot_kick     (bot_kick),
        .player_kick  (player_kick),
        .botTLY       (botTLY),
        .playerTLY    (playerTLY),
        .ballTLY      (ballTLY),
        .load_speed   (load_speed),
        .Xspeed_out   (Xspeed_out),
        .Yspeed_out   (Yspeed_out),
        .kicker       (kicker),
        .busy         (busy)
`ifdef KICK_STATS_EN
        ,
        .bot_kicks    (bot_kicks),
        .player_kicks (player_kicks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int frameLen    = 5;
    int framePhase  = 0;
    int strobeCount = 0;

    // Reference model: a kick owns the controller from acceptance until
    // HOLD + 1 + COOL frame pulses have passed; the first HOLD of those
    // pulses each produce a strobe one cycle later.
    bit mBusy;
    int mFrames;
    bit mLoad;
    int mX;
    int mY;
    bit mKicker;
    bit mPrevBot;
    bit mPrevPlayer;
    int mBotKicks;
    int mPlayerKicks;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelClear();
        mBusy        = 1'b0;
        mFrames      = 0;
        mLoad        = 1'b0;
        mX           = 0;
        mY           = 0;
        mKicker      = 1'b0;
        mPrevBot     = 1'b1;
        mPrevPlayer  = 1'b1;
        mBotKicks    = 0;
        mPlayerKicks = 0;
    endtask

    function automatic int shapeY(input int rodY, input int ballY);
        int yc;
        yc = (ballY - (rodY + HALF_H)) * GAIN;
        if (yc > SPEED_YMX)  yc = SPEED_YMX;
        if (yc < -SPEED_YMX) yc = -SPEED_YMX;
        return yc;
    endfunction

    // Predict the effect of the inputs currently driven at the next edge.
    task automatic modelStep();
        bit be;
        bit pe;
        if (reset) begin
            modelClear();
            return;
        end
        be    = bot_kick && !mPrevBot;
        pe    = player_kick && !mPrevPlayer;
        mLoad = 1'b0;
        if (!mBusy) begin
            if (pe || be) begin
                mKicker = pe ? 1'b0 : 1'b1;
                mX      = pe ? -SPEED_X : SPEED_X;
                mY      = shapeY(pe ? int'($signed(playerTLY)) : int'($signed(botTLY)), int'(ballTLY));
                mBusy   = 1'b1;
                mFrames = 0;
                if (pe) mPlayerKicks = (mPlayerKicks < 255) ? mPlayerKicks + 1 : 255;
                else    mBotKicks    = (mBotKicks < 255) ? mBotKicks + 1 : 255;
            end
        end else if (startOfFrame) begin
            mFrames++;
            if (mFrames <= HOLD) mLoad = 1'b1;
            if (mFrames == HOLD + 1 + COOL) mBusy = 1'b0;
        end
        mPrevBot    = bot_kick;
        mPrevPlayer = player_kick;
    endtask

    task automatic compareAll();
        checkOutput("load", int'(load_speed), int'(mLoad));
        checkOutput("busy", int'(busy), int'(mBusy));
        checkOutput("xspeed", int'(Xspeed_out), mX);
        checkOutput("yspeed", int'(Yspeed_out), mY);
        checkOutput("kicker", int'(kicker), int'(mKicker));
`ifdef KICK_STATS_EN
        checkOutput("botKicks", int'(bot_kicks), mBotKicks);
        checkOutput("playerKicks", int'(player_kicks), mPlayerKicks);
`endif
    endtask

    // One clock: generate the frame pulse, predict, clock, then check.
    task automatic applyStimulus();
        startOfFrame = (framePhase == 0);
        framePhase   = (framePhase + 1) % frameLen;
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
        if (load_speed) strobeCount++;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (3) applyStimulus();
        reset = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        for (int i = 0; i < maxCycles && busy; i++) applyStimulus();
        checkOutput("idleTimeout", int'(busy), 0);
    endtask

    task automatic pulseBot();
        bot_kick = 1'b1;
        applyStimulus();
        bot_kick = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        bot_kick     = 1'b0;
        player_kick  = 1'b0;
        botTLY       = 11'd0;
        playerTLY    = 11'd0;
        ballTLY      = 11'd0;
        modelClear();

        $display("[TB] reset state");
        doReset();
        repeat (4) applyStimulus();

        $display("[TB] bot kick, positive offset");
        botTLY      = 11'd100;
        ballTLY     = 11'd120;
        strobeCount = 0;
        pulseBot();
        checkOutput("botX", int'(Xspeed_out), 300);
        checkOutput("botY", int'(Yspeed_out), 16);
        checkOutput("botKicker", int'(kicker), 1);
        waitIdle(400);
        checkOutput("botStrobes", strobeCount, 4);

        $display("[TB] player kick, clamped negative offset");
        playerTLY   = 11'd300;
        ballTLY     = 11'd200;
        player_kick = 1'b1;
        applyStimulus();
        player_kick = 1'b0;
        checkOutput("plyX", int'(Xspeed_out), -300);
        checkOutput("plyY", int'(Yspeed_out), -150);
        checkOutput("plyKicker", int'(kicker), 0);
        waitIdle(400);

        $display("[TB] simultaneous kicks");
        bot_kick    = 1'b1;
        player_kick = 1'b1;
        applyStimulus();
        bot_kick    = 1'b0;
        player_kick = 1'b0;
        checkOutput("simKicker", int'(kicker), 0);
        checkOutput("simX", int'(Xspeed_out), -300);
        waitIdle(400);

        $display("[TB] bot kick during cooldown is dropped");
        botTLY      = 11'd100;
        ballTLY     = 11'd120;
        strobeCount = 0;
        pulseBot();
        for (int i = 0; i < 400 && mFrames < HOLD + 3; i++) applyStimulus();
        botTLY = 11'd0;
        pulseBot();
        waitIdle(400);
        checkOutput("coolStrobes", strobeCount, 4);
        checkOutput("coolX", int'(Xspeed_out), 300);
        checkOutput("coolY", int'(Yspeed_out), 16);

        $display("[TB] kick held through reset release");
        bot_kick = 1'b1;
        doReset();
        repeat (12) applyStimulus();
        checkOutput("heldNoKick", int'(busy), 0);
        bot_kick = 1'b0;
        repeat (2) applyStimulus();

        $display("[TB] reset during hold");
        strobeCount = 0;
        pulseBot();
        for (int i = 0; i < 400 && strobeCount < 2; i++) applyStimulus();
        checkOutput("twoStrobes", strobeCount, 2);
        reset = 1'b1;
        #1;
        modelClear();
        compareAll();
        repeat (2) applyStimulus();
        reset       = 1'b0;
        strobeCount = 0;
        repeat (60) applyStimulus();
        checkOutput("noStrobeAfterRst", strobeCount, 0);

        $display("[TB] randomized kicks");
        for (int k = 0; k < 6; k++) begin
            frameLen   = $urandom_range(2, 6);
            framePhase = 0;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 11) == 0) bot_kick = ~bot_kick;
                if ($urandom_range(0, 13) == 0) player_kick = ~player_kick;
                botTLY    = 11'(int'($urandom_range(0, 527)) - 64);
                playerTLY = 11'(int'($urandom_range(0, 527)) - 64);
                ballTLY   = 11'($urandom_range(0, 479));
                applyStimulus();
            end
        end
        bot_kick    = 1'b0;
        player_kick = 1'b0;
        waitIdle(400);

`ifdef KICK_STATS_EN
        $display("[TB] kick counter saturation");
        frameLen   = 2;
        framePhase = 0;
        doReset();
        for (int n = 0; n < 260; n++) begin
            pulseBot();
            waitIdle(200);
        end
        checkOutput("botKicksSat", int'(bot_kicks), 255);
        checkOutput("playerKicksZero", int'(player_kicks), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
